// File: rtl/rominit_multi.sv
// Routes the hps_io ioctl byte stream into NREG ROM regions through a small FIFO.
// Also reports per-download length, completion pulse and sticky drop error.
module rominit_multi #(
    parameter int                     NREG      = 3,
    parameter int                     AW        = 17,
    parameter int                     DEPTH     = 4,
    parameter logic [8*NREG-1:0]      REG_INDEX = {8'd1, 8'd0, 8'd0},
    parameter logic [25*NREG-1:0]     REG_BASE  = {25'h0, 25'h1000, 25'h0},
    parameter logic [(AW+1)*NREG-1:0] REG_SIZE  = {18'h20000, 18'h400, 18'h1000}
) (
    input  logic            CLK_SYS,
    input  logic            RESET,
    input  logic            IOCTL_DOWNLOAD,
    input  logic [7:0]      IOCTL_INDEX,
    input  logic            IOCTL_WR,
    input  logic [24:0]     IOCTL_ADDR,
    input  logic [7:0]      IOCTL_DOUT,
    output logic            IOCTL_WAIT,
    output logic [NREG-1:0] ROMINIT_SEL,
    output logic [AW-1:0]   ROMINIT_ADDR,
    output logic [7:0]      ROMINIT_DATA,
    output logic            ROMINIT_VALID,
    input  logic            ROMINIT_READY,
    output logic            ROMINIT_ACTIVE,
    output logic [AW:0]     ROMINIT_LEN,
    output logic            ROMINIT_DONE,
    output logic            ROMINIT_ERR
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = NREG + AW + 8;
    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic            dl_q;
    logic            rise;
    logic            fall;
    logic            hit;
    logic [NREG-1:0] hit_sel;
    logic [AW-1:0]   hit_addr;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            empty;
    logic            full;
    logic            wr_load;
    logic            push;
    logic            pop;
    logic            drop;

    assign rise = IOCTL_DOWNLOAD & ~dl_q;
    assign fall = ~IOCTL_DOWNLOAD & dl_q;

    // Descending scan so the lowest matching region overwrites any higher one.
    always_comb begin
        logic [25:0] addr26;
        logic [25:0] base26;
        logic [25:0] end26;
        hit      = 1'b0;
        hit_sel  = '0;
        hit_addr = '0;
        addr26   = {1'b0, IOCTL_ADDR};
        base26   = '0;
        end26    = '0;
        for (int r = NREG - 1; r >= 0; r--) begin
            base26 = {1'b0, REG_BASE[25*r +: 25]};
            end26  = base26 + 26'(REG_SIZE[(AW+1)*r +: AW+1]);
            if (IOCTL_INDEX == REG_INDEX[8*r +: 8] && addr26 >= base26 && addr26 < end26) begin
                hit         = 1'b1;
                hit_sel     = '0;
                hit_sel[r]  = 1'b1;
                hit_addr    = AW'(IOCTL_ADDR - REG_BASE[25*r +: 25]);
            end
        end
    end

    // Handshake: an entry transfers on any clock edge where VALID and READY are
    // both high; while VALID is high and READY low the head entry holds steady.
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = ~empty & ROMINIT_READY;
    assign wr_load = IOCTL_WR & (state == S_LOAD);
    assign push    = wr_load & hit & (~full | pop);
    assign drop    = wr_load & ~push;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (push) begin
            mem[wr_ptr] <= {hit_sel, hit_addr, IOCTL_DOUT};
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    assign head          = mem[rd_ptr];
    assign ROMINIT_VALID = ~empty;
    assign ROMINIT_SEL   = empty ? '0 : head[EW-1 -: NREG];
    assign ROMINIT_ADDR  = empty ? '0 : head[AW+7:8];
    assign ROMINIT_DATA  = empty ? '0 : head[7:0];

    // dl_q loads the live level on reset so a download already in progress
    // is not seen as a fresh rising edge afterwards.
    always_ff @(posedge CLK_SYS) begin
        if (RESET) begin
            state          <= S_IDLE;
            dl_q           <= IOCTL_DOWNLOAD;
            IOCTL_WAIT     <= 1'b0;
            ROMINIT_ACTIVE <= 1'b0;
            ROMINIT_LEN    <= '0;
            ROMINIT_DONE   <= 1'b0;
            ROMINIT_ERR    <= 1'b0;
        end else begin
            dl_q         <= IOCTL_DOWNLOAD;
            ROMINIT_DONE <= 1'b0;
            if (push && ROMINIT_LEN != LEN_MAX) ROMINIT_LEN <= ROMINIT_LEN + 1'b1;
            if (drop) ROMINIT_ERR <= 1'b1;
            case (state)
                S_IDLE: begin
                    IOCTL_WAIT <= 1'b0;
                    if (rise) begin
                        state          <= S_LOAD;
                        ROMINIT_ACTIVE <= 1'b1;
                        ROMINIT_LEN    <= '0;
                        ROMINIT_ERR    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    IOCTL_WAIT <= (count_nxt >= CW'(DEPTH - 1));
                    if (fall) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    IOCTL_WAIT <= (count_nxt >= CW'(DEPTH - 1));
                    if (rise) begin
                        state       <= S_LOAD;
                        ROMINIT_LEN <= '0;
                        ROMINIT_ERR <= 1'b0;
                    end else if (count_nxt == '0) begin
                        state        <= S_DONE;
                        ROMINIT_DONE <= 1'b1;
                        IOCTL_WAIT   <= 1'b0;
                    end
                end
                S_DONE: begin
                    IOCTL_WAIT     <= 1'b0;
                    ROMINIT_ACTIVE <= 1'b0;
                    state          <= S_IDLE;
                    if (rise) begin
                        state          <= S_LOAD;
                        ROMINIT_ACTIVE <= 1'b1;
                        ROMINIT_LEN    <= '0;
                        ROMINIT_ERR    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rominit_multi.sv
// Bench for rominit_multi: decode table, directed multi-cycle sequences and
// randomized downloads checked against a region/queue reference model.
`timescale 1ns/1ps
module tb_rominit_multi;
    localparam int NREG  = 3;
    localparam int AW    = 17;
    localparam int DEPTH = 4;
    localparam int EW    = NREG + AW + 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            download = 1'b0;
    logic [7:0]      index = '0;
    logic            wr = 1'b0;
    logic [24:0]     addr = '0;
    logic [7:0]      dout = '0;
    logic            wait_o;
    logic [NREG-1:0] sel;
    logic [AW-1:0]   raddr;
    logic [7:0]      rdata;
    logic            valid;
    logic            ready = 1'b0;
    logic            active;
    logic [AW:0]     len;
    logic            done;
    logic            err;

    rominit_multi dut (
        .CLK_SYS(clk), .RESET(reset), .IOCTL_DOWNLOAD(download), .IOCTL_INDEX(index),
        .IOCTL_WR(wr), .IOCTL_ADDR(addr), .IOCTL_DOUT(dout), .IOCTL_WAIT(wait_o),
        .ROMINIT_SEL(sel), .ROMINIT_ADDR(raddr), .ROMINIT_DATA(rdata),
        .ROMINIT_VALID(valid), .ROMINIT_READY(ready), .ROMINIT_ACTIVE(active),
        .ROMINIT_LEN(len), .ROMINIT_DONE(done), .ROMINIT_ERR(err)
    );

    always #5 clk = ~clk;

    // Region map as plain integers.
    int reg_idx[NREG]  = '{0, 0, 1};
    int reg_base[NREG] = '{0, 'h1000, 0};
    int reg_size[NREG] = '{'h1000, 'h400, 'h20000};

    logic [EW-1:0] exp_q[$];
    bit m_load;
    bit dl_prev;
    int m_len;
    bit m_err;
    int n_checks;
    int n_fail;
    int done_seen;

    typedef struct {
        int idx;
        int a;
        bit hit;
        logic [NREG-1:0] s;
        int ra;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic bit decode(input int idx, input int a, input logic [7:0] d,
                                  output logic [EW-1:0] ent);
        logic [NREG-1:0] s;
        logic [AW-1:0]   ra;
        ent = '0;
        for (int r = 0; r < NREG; r++) begin
            if (idx == reg_idx[r] && a >= reg_base[r] && a < reg_base[r] + reg_size[r]) begin
                s   = '0;
                s[r] = 1'b1;
                ra  = AW'(a - reg_base[r]);
                ent = {s, ra, d};
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One clock: check the head against the model, advance the model, clock.
    task automatic step();
        logic [EW-1:0] e;
        bit pop;
        bit hit;
        if (reset) begin
            exp_q.delete();
            m_load = 1'b0;
            m_len  = 0;
            m_err  = 1'b0;
        end else begin
            check("valid", valid, exp_q.size() != 0);
            pop = ready && exp_q.size() != 0;
            if (pop) begin
                e = exp_q.pop_front();
                check("head_entry", {sel, raddr, rdata}, e);
            end
            if (wr && m_load) begin
                hit = decode(int'(index), int'(addr), dout, e);
                if (hit && exp_q.size() < DEPTH) begin
                    exp_q.push_back(e);
                    if (m_len < (1 << AW)) m_len++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (download && !dl_prev && !m_load) begin
                m_load = 1'b1;
                m_len  = 0;
                m_err  = 1'b0;
            end else if (!download && dl_prev) begin
                m_load = 1'b0;
            end
        end
        dl_prev = download;
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic dl_start(input int idx);
        index = 8'(idx);
        download = 1'b1;
        step();
    endtask

    task automatic dl_end();
        wr = 1'b0;
        download = 1'b0;
        step();
    endtask

    task automatic strobe(input int a, input logic [7:0] d);
        addr = 25'(a);
        dout = d;
        wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        check(name, done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        vecs[0] = '{0, 'h0000,    1, 3'b001, 'h0};
        vecs[1] = '{0, 'h0FFF,    1, 3'b001, 'hFFF};
        vecs[2] = '{0, 'h1000,    1, 3'b010, 'h0};
        vecs[3] = '{0, 'h13FF,    1, 3'b010, 'h3FF};
        vecs[4] = '{0, 'h1400,    0, 3'b000, 0};
        vecs[5] = '{1, 'h0,       1, 3'b100, 'h0};
        vecs[6] = '{1, 'h1FFFF,   1, 3'b100, 'h1FFFF};
        vecs[7] = '{1, 'h20000,   0, 3'b000, 0};
        vecs[8] = '{2, 'h0,       0, 3'b000, 0};
        vecs[9] = '{0, 'h1FFFFFF, 0, 3'b000, 0};

        do_reset();
        check("rst_valid", valid, 0);
        check("rst_wait", wait_o, 0);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_len", len, 0);
        check("rst_err", err, 0);
        check("rst_sel", sel, 0);

        // Full stream through regions 0 and 1.
        ready = 1'b1;
        dl_start(0);
        check("t1_active", active, 1);
        for (int a = 0; a < 'h1400; a++) strobe(a, 8'(a) ^ 8'h5A);
        dl_end();
        wait_done("t1_done", 20);
        check("t1_len", len, 'h1400);
        check("t1_err", err, 0);
        check("t1_drained", exp_q.size(), 0);
        step();
        check("t1_done_pulse", done, 0);
        check("t1_inactive", active, 0);

        // Decode boundary table.
        dl_start(0);
        foreach (vecs[i]) begin
            index = 8'(vecs[i].idx);
            strobe(vecs[i].a, 8'(8'h30 + i));
            check($sformatf("tbl%0d_valid", i), valid, vecs[i].hit);
            check($sformatf("tbl%0d_sel", i), sel, vecs[i].s);
            if (vecs[i].hit) check($sformatf("tbl%0d_addr", i), raddr, vecs[i].ra);
            step();
        end
        dl_end();
        wait_done("tbl_done", 20);
        check("tbl_len", len, 6);
        check("tbl_err", err, 1);

        // Back-pressure: WAIT at three queued, drop when full.
        ready = 1'b0;
        dl_start(1);
        for (int i = 0; i < 16; i++) begin
            strobe(i, 8'(8'hA0 + i));
            if (i == 1) check("t2_wait_2", wait_o, 0);
            if (i == 2) check("t2_wait_3", wait_o, 1);
            if (i == 3) check("t2_err_4", err, 0);
            if (i == 4) check("t2_err_5", err, 1);
        end
        check("t2_sel", sel, 3'b100);
        ready = 1'b1;
        step();
        check("t2_wait_cnt3", wait_o, 1);
        step();
        check("t2_wait_cnt2", wait_o, 0);
        step();
        step();
        check("t2_drained", exp_q.size(), 0);
        dl_end();
        wait_done("t2_done", 20);
        check("t2_len", len, 4);

        // Miss only: nothing queued, ERR set, DONE still pulses.
        dl_start(0);
        strobe('h1400, 8'h11);
        step();
        check("t3_err", err, 1);
        check("t3_len", len, 0);
        dl_end();
        wait_done("t3_done", 20);

        // Stalled target during fall: DONE the cycle after the last pop.
        ready = 1'b0;
        dl_start(0);
        strobe('h10, 8'h21);
        strobe('h11, 8'h22);
        dl_end();
        for (int i = 0; i < 3; i++) step();
        check("t4_active", active, 1);
        check("t4_no_done", done, 0);
        ready = 1'b1;
        step();
        check("t4_done_early", done, 0);
        step();
        check("t4_done", done, 1);
        step();
        check("t4_done_clear", done, 0);
        check("t4_inactive", active, 0);

        // Reset in the middle of a download.
        ready = 1'b0;
        dl_start(0);
        for (int i = 0; i < 3; i++) strobe('h100 + i, 8'(i));
        d0 = done_seen;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_valid", valid, 0);
        check("t5_wait", wait_o, 0);
        check("t5_active", active, 0);
        strobe('h200, 8'h77);
        strobe('h201, 8'h78);
        step();
        check("t5_ignored", valid, 0);
        check("t5_err", err, 0);
        check("t5_still_idle", active, 0);
        download = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_no_done", done_seen, d0);

        // New download while the previous one is still draining.
        ready = 1'b0;
        dl_start(1);
        strobe('h40, 8'hC0);
        strobe('h41, 8'hC1);
        download = 1'b0;
        step();
        step();
        d0 = done_seen;
        download = 1'b1;
        step();
        check("t6_len_clear", len, 0);
        check("t6_active", active, 1);
        strobe('h50, 8'hD0);
        strobe('h51, 8'hD1);
        ready = 1'b1;
        dl_end();
        wait_done("t6_done", 20);
        check("t6_one_done", done_seen, d0 + 1);
        check("t6_len", len, 2);
        check("t6_drained", exp_q.size(), 0);

        // Randomized downloads against the model.
        for (int round = 0; round < 6; round++) begin
            dl_start($urandom_range(0, 2));
            for (int c = 0; c < 300; c++) begin
                wr    = ($urandom_range(0, 99) < 70);
                ready = $urandom_range(0, 1);
                if ($urandom_range(0, 9) == 0) index = 8'($urandom_range(0, 2));
                case ($urandom_range(0, 3))
                    0: addr = 25'($urandom_range(0, 'h1500));
                    1: addr = 25'($urandom_range('h0FFC, 'h1003));
                    2: addr = 25'($urandom_range('h1FFFC, 'h20003));
                    default: addr = 25'($urandom);
                endcase
                dout = 8'($urandom);
                step();
            end
            wr = 1'b0;
            ready = 1'b1;
            dl_end();
            wait_done($sformatf("rnd%0d_done", round), 20);
            check($sformatf("rnd%0d_len", round), len, m_len);
            check($sformatf("rnd%0d_err", round), err, m_err);
            check($sformatf("rnd%0d_drained", round), exp_q.size(), 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rominit_multi.md
Name: rominit_multi

Overview:
Parametrised successor to the download manager. It routes the hps_io ioctl byte stream into NREG ROM regions, each selected by ioctl index and address window. Accepted bytes pass through a small FIFO to a target that can stall via valid/ready; IOCTL_WAIT back-pressures the HPS. It also reports per-download length, completion and error status. It sits between hps_io and scv in the emu top.

Parameters:
NREG, 3, number of regions
AW, 17, region-relative address width
DEPTH, 4, FIFO entries (power of 2, >=2)
REG_INDEX, {8'd1,8'd0,8'd0}, packed 8*NREG; ioctl index for region r at [8r+:8]
REG_BASE, {25'h0,25'h1000,25'h0}, packed 25*NREG; first ioctl address of region r
REG_SIZE, {18'h20000,18'h400,18'h1000}, packed (AW+1)*NREG; region size in bytes (>=1)

Ports:
CLK_SYS  in  1  system clock
RESET  in  1  synchronous active-high reset
IOCTL_DOWNLOAD  in  1  download in progress
IOCTL_INDEX  in  8  file index
IOCTL_WR  in  1  byte strobe
IOCTL_ADDR  in  25  byte address
IOCTL_DOUT  in  8  byte data
IOCTL_WAIT  out  1  stall request to hps_io
ROMINIT_SEL  out  NREG  one-hot region of head entry
ROMINIT_ADDR  out  AW  region-relative address of head entry
ROMINIT_DATA  out  8  head data
ROMINIT_VALID  out  1  head entry valid
ROMINIT_READY  in  1  target accepts head entry
ROMINIT_ACTIVE  out  1  download in progress or draining
ROMINIT_LEN  out  AW+1  bytes accepted in current/last download
ROMINIT_DONE  out  1  one-cycle completion pulse
ROMINIT_ERR  out  1  sticky: byte dropped in current/last download

Behaviour:
- Reset: all outputs 0, FIFO flushed, state IDLE. Reset mid-download: no DONE; ACTIVE stays 0 until the next IOCTL_DOWNLOAD rising edge, even if DOWNLOAD is still high.
- Edge detect: DOWNLOAD registered once; rise/fall are computed against the registered copy.
- States:
  - IDLE -> LOAD on rise: LEN<=0, ERR<=0, ACTIVE<=1.
  - LOAD -> DRAIN on fall.
  - DRAIN -> DONE when FIFO is empty. DRAIN -> LOAD on rise: the previous DONE is suppressed, LEN and ERR are cleared, and already-queued entries still drain.
  - DONE: DONE=1 for exactly one cycle, ACTIVE<=0, then IDLE.
- Decode (LOAD only): region r hits when IOCTL_INDEX==REG_INDEX[r] and REG_BASE[r] <= IOCTL_ADDR < REG_BASE[r]+REG_SIZE[r], using 26-bit compare with no wrap. The lowest r wins on overlap. Entry address = (IOCTL_ADDR-REG_BASE[r])[AW-1:0].
- Push on IOCTL_WR in LOAD with a hit and FIFO not full.
  - Miss: byte is dropped, ERR<=1.
  - WR while full: byte is dropped, ERR<=1.
  - WR outside LOAD: ignored, no ERR.
- LEN increments per push and saturates at 2^AW.
- Pop when VALID & READY. VALID = FIFO not empty. SEL/ADDR/DATA show the head entry, stable while VALID & !READY. SEL is 0 when empty.
- Push and pop in the same cycle: count unchanged, legal at full or empty. Push into empty: VALID rises the next cycle, so latency is 1 cycle.
- IOCTL_WAIT is registered, =1 when next count >= DEPTH-1. This leaves one slot for a strobe already in flight. It is 0 in IDLE and DONE.
- Count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.

Test Plan:
- Default params, index 0, write addr 0x0000..0x13FF with READY=1: 4096 entries SEL=001 ADDR 0..0xFFF, then 1024 entries SEL=010 ADDR 0..0x3FF. After fall: DONE pulse, LEN=0x1400, ERR=0.
- Index 1, 16 bytes, READY=0: after 3 pushes WAIT=1. A 5th strobe while full is dropped and sets ERR=1. Raise READY: 4 entries SEL=100 in order, WAIT drops when count<3.
- Index 0, addr 0x1400 (outside all windows): no VALID, ERR=1, LEN=0, DONE still pulses after fall.
- READY=0 during fall with 2 queued: ACTIVE stays 1 and there is no DONE. Release READY: DONE occurs the cycle after the last pop.
- Assert RESET mid-download with 3 queued: VALID=0, WAIT=0, ACTIVE=0. Further strobes are ignored until the next rise, and no DONE occurs.
- New rise during DRAIN: previous DONE suppressed, LEN restarts at 0, old entries still delivered before new ones.
